// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : screen geometry, fill defaults and fill-engine state encoding
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int SCREEN_W            = 640;
    localparam int SCREEN_H            = 480;
    localparam int ROW_BYTES           = 320;
    localparam int ACK_TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_NEXT      = 3'd5,
        ST_DONE      = 3'd6
    } fill_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_fill_addr.sv
// ============================================================================
// vga_fill_addr : row base / column counters and byte address for the filler
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module vga_fill_addr
    import vga_pkg::*;
#(
    parameter logic [25:0] VIDEO_BASE = 26'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [9:0]  x0,
    input  logic [8:0]  y0,
    input  logic [8:0]  bytes_per_row,
    input  logic [8:0]  rows,
    output logic [25:0] address,
    output logic        last_byte
);

    logic [25:0] row_base_q, row_base_d;
    logic [8:0]  col_q, col_d;
    logic [8:0]  row_q, row_d;
    logic [25:0] y_ext;
    logic        last_col;
    logic        last_row;

    assign y_ext     = {17'd0, y0};
    assign last_col  = (col_q == bytes_per_row - 9'd1);
    assign last_row  = (row_q == rows - 9'd1);
    assign last_byte = last_col && last_row;
    assign address   = row_base_q + {17'd0, col_q};

    always_comb begin
        row_base_d = row_base_q;
        col_d      = col_q;
        row_d      = row_q;
        if (load) begin
            // y0*320 built from shifts: 256*y0 + 64*y0
            row_base_d = VIDEO_BASE + (y_ext << 8) + (y_ext << 6) + {17'd0, x0[9:1]};
            col_d      = 9'd0;
            row_d      = 9'd0;
        end else if (advance) begin
            if (last_col) begin
                row_base_d = row_base_q + 26'(ROW_BYTES);
                col_d      = 9'd0;
                row_d      = row_q + 9'd1;
            end else begin
                col_d      = col_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base_q <= 26'd0;
            col_q      <= 9'd0;
            row_q      <= 9'd0;
        end else begin
            row_base_q <= row_base_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_fill.sv
// ============================================================================
// vga_fill : fills a 4-bpp rectangle of the 640x480 frame buffer, one byte
//            per controller handshake
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module vga_fill
    import vga_pkg::*;
#(
    parameter logic [25:0] VIDEO_BASE  = 26'd0,
    parameter int          ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic        clock_100_mhz,
    input  logic        reset_n,
    input  logic        start,
    input  logic [9:0]  x0,
    input  logic [8:0]  y0,
    input  logic [9:0]  w,
    input  logic [8:0]  h,
    input  logic [3:0]  color,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [25:0] mem_address,
    output logic        mem_we,
    output logic [7:0]  mem_data,
    input  logic        mem_ready
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    fill_state_t      state_q, state_d;
    logic [9:0]       x0_q, x0_d, w_q, w_d;
    logic [8:0]       y0_q, y0_d, h_q, h_d;
    logic [3:0]       color_q, color_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             error_q, error_d;
    logic             load;
    logic             advance;
    logic             last_byte;
    logic [10:0]      x_end;
    logic [10:0]      y_end;
    logic             reject;

    // Sums kept at 11 bits so an oversized rectangle cannot wrap into range
    assign x_end  = {1'b0, x0_q} + {1'b0, w_q};
    assign y_end  = {2'b0, y0_q} + {2'b0, h_q};
    assign reject = (w_q == 10'd0) || (h_q == 9'd0) || x0_q[0] || w_q[0] ||
                    (x_end > 11'(SCREEN_W)) || (y_end > 11'(SCREEN_H));

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        timer_d = timer_q;
        error_d = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    w_d     = w;
                    h_d     = h;
                    color_d = color;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (reject) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // A write the controller suppresses never drops mem_ready
                if (!mem_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_NEXT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (mem_ready) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (last_byte) begin
                    state_d = ST_DONE;
                end else begin
                    advance = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100_mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            x0_q    <= 10'd0;
            y0_q    <= 9'd0;
            w_q     <= 10'd0;
            h_q     <= 9'd0;
            color_q <= 4'd0;
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end

    assign busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK) ||
                      (state_q == ST_WAIT_DONE) || (state_q == ST_NEXT);
    assign mem_we   = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK) ||
                      (state_q == ST_WAIT_DONE);
    assign done     = (state_q == ST_DONE);
    assign error    = error_q;
    assign mem_data = {color_q, color_q};

    vga_fill_addr #(
        .VIDEO_BASE (VIDEO_BASE)
    ) u_addr (
        .clk           (clock_100_mhz),
        .rst_n         (reset_n),
        .load          (load),
        .advance       (advance),
        .x0            (x0_q),
        .y0            (y0_q),
        .bytes_per_row (w_q[9:1]),
        .rows          (h_q),
        .address       (mem_address),
        .last_byte     (last_byte)
    );

endmodule

`default_nettype wire
